ux607_dtag_ram_mway: RTL and testbench
======================================

// Module: ux607_dtag_ram_mway
// PURPOSE
//  Multi-way D-cache tag RAM with built-in invalidate sweep. Next generation of the single-way
//  dtag RAM: NWAYS tag ways share one address, with per-way and per-bit write enables.
//  A hardware init FSM clears every entry after reset or on request.
//  Sits between the DCache controller (lookup/refill/evict) and the tag storage.
// PARAMETERS
//  NWAYS     2    number of tag ways read/written in parallel
//  DP        64   entries (sets) per way
//  AW        6    address width, must equal clog2(DP)
//  DW        22   tag entry width per way (tag+valid+dirty, ECC bits if present)
//  INIT_VAL  0    DW-bit value written to every entry by the init sweep
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous active-high reset
//  ls           in   1         light-sleep; while high no request is accepted
//  init_req     in   1         pulse: start a full invalidate sweep
//  init_busy    out  1         sweep in progress
//  req_valid    in   1         request valid
//  req_ready    out  1         request accepted when req_valid&&req_ready
//  req_wen      in   1         1=write, 0=read
//  req_addr     in   AW        set index
//  req_way_en   in   NWAYS     per-way write enable (ignored for reads)
//  req_wmask    in   DW        per-bit write mask, common to all enabled ways
//  req_wdata    in   NWAYS*DW  write data, way w at [w*DW +: DW]
//  rsp_valid    out  1         read data valid
//  rsp_rdata    out  NWAYS*DW  read data, way w at [w*DW +: DW]
// BEHAVIOUR
//  - FSM: INIT, READY. Reset -> INIT, sweep counter=0, rsp_valid=0, rsp_rdata=0, init_busy=1.
//  - INIT: each cycle writes INIT_VAL to entry[cnt] of every way; cnt++.
//    At cnt==DP-1 write then go READY; the sweep takes exactly DP cycles.
//    init_busy=1 and req_ready=0 throughout INIT.
//  - READY: req_ready = !ls (combinational from ls and state only, never from req_valid).
//  - init_req sampled high in READY: state -> INIT, cnt=0 next cycle.
//    A request accepted in that same cycle still completes. init_req during INIT is ignored.
//  - rst mid-sweep: sweep restarts from cnt=0; entries already cleared stay cleared.
//  - Read accepted at cycle N: rsp_valid=1 at N+1, rsp_rdata = all ways of entry[req_addr].
//    No read-during-write conflict: single port, one op per cycle.
//  - rsp_valid is a 1-cycle pulse. rsp_rdata holds its last read value until the next read
//    response; it is not changed by writes, sweeps or ls.
//  - Write accepted: for each way w with req_way_en[w]=1, each bit b with req_wmask[b]=1:
//    entry[w][addr][b] <= req_wdata[w*DW+b]. Other bits/ways unchanged.
//    The write is visible to a read accepted the next cycle. No response is produced.
//  - Write with req_way_en=0 or req_wmask=0 is accepted and is a no-op.
//  - Back-to-back reads: one per cycle, rsp_valid stays high for consecutive responses.
//  - ls rising while a response is pending: the response is still delivered at N+1.
//  - Storage is flop/RAM array without reset; only the sweep defines contents.
//    X never reaches rsp_rdata after the first sweep completes.
// TESTING
//  1 rst high 1 cyc then low -> init_busy=1, req_ready=0 for 64 cyc; every read then returns 0.
//  2 write addr=5, way_en=2'b10, wmask=all1, wdata={22'h3ABCDE,22'h111111}; read addr=5
//    -> rsp_rdata={22'h3ABCDE,22'h000000} one cycle after accept.
//  3 after 2: write addr=5, way_en=2'b11, wmask=22'h00000F, wdata={22'h3FFFFF,22'h3FFFFF}
//    -> read gives {22'h3ABCDF,22'h00000F}.
//  4 reads addr=0..3 back-to-back -> rsp_valid high 4 consecutive cycles, data in order.
//    ls=1 -> req_ready=0 and rsp_rdata holds.
//  5 init_req in READY with a write accepted same cycle -> write done, then 64-cyc sweep;
//    addr=5 reads 0 afterwards.
//  6 rst at cnt=30 of a sweep -> sweep restarts, init_busy falls exactly 64 cyc after rst low.

Source files
------------

// File: rtl/ux607_dtag_ram_mway.sv
// ---------------------------------------------------------------------------
// ux607_dtag_ram_mway
//   Multi-way D-cache tag RAM with a built-in invalidate sweep. NWAYS tag
//   ways share one set index; writes carry a per-way enable and a per-bit
//   mask common to all enabled ways. A hardware sweep writes INIT_VAL to
//   every entry of every way after reset or when init_req is pulsed.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   ls           light-sleep, blocks request acceptance while high
//   init_req     pulse, start an invalidate sweep (honoured in READY only)
//   init_busy    sweep in progress
//   req_*        single-port request: valid/ready handshake, wen, addr,
//                way_en, wmask, wdata (way w at [w*DW +: DW])
//   rsp_valid    1-cycle pulse, read data valid one cycle after accept
//   rsp_rdata    all ways of the read entry; holds until the next read
// ---------------------------------------------------------------------------
module ux607_dtag_ram_mway #(
    parameter int              NWAYS    = 2,
    parameter int              DP       = 64,
    parameter int              AW       = 6,
    parameter int              DW       = 22,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ls,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [AW-1:0]         req_addr,
    input  logic [NWAYS-1:0]      req_way_en,
    input  logic [DW-1:0]         req_wmask,
    input  logic [NWAYS*DW-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [NWAYS*DW-1:0]   rsp_rdata
);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            sweep_we;
    logic            req_acc_p0;

    // Tag storage: no reset, contents are defined only by the sweep.
    logic [DW-1:0]   mem [NWAYS][DP];

    logic                  vld_p1;
    logic [NWAYS*DW-1:0]   rdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ready depends only on state and ls so it never loops back through
    // req_valid; an init_req in READY does not block the same-cycle request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        req_ready = 1'b0;
        sweep_we  = 1'b0;
        case (state_q)
            S_INIT: begin
                init_busy = 1'b1;
                sweep_we  = 1'b1;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(DP - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                req_ready = !ls;
                if (init_req) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign req_acc_p0 = req_valid && req_ready;

    // Stage p0: storage update (sweep and requests are mutually exclusive
    // because req_ready is low during INIT).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_we) begin
                for (int w = 0; w < NWAYS; w++) begin
                    mem[w][cnt_q] <= INIT_VAL;
                end
            end else if (req_acc_p0 && req_wen) begin
                for (int w = 0; w < NWAYS; w++) begin
                    if (req_way_en[w]) begin
                        mem[w][req_addr] <= (mem[w][req_addr] & ~req_wmask)
                                          | (req_wdata[w*DW +: DW] & req_wmask);
                    end
                end
            end
        end
    end

    // Stage p1: read response register; data only changes on a read accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= req_acc_p0 && !req_wen;
            if (req_acc_p0 && !req_wen) begin
                for (int w = 0; w < NWAYS; w++) begin
                    rdata_p1[w*DW +: DW] <= mem[w][req_addr];
                end
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_ux607_dtag_ram_mway.sv
module tb_ux607_dtag_ram_mway;

    localparam int NWAYS = 2;
    localparam int DP    = 64;
    localparam int AW    = 6;
    localparam int DW    = 22;
    localparam int RW    = NWAYS * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            ls;
    logic            init_req;
    logic            init_busy;
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [AW-1:0]   req_addr;
    logic [NWAYS-1:0] req_way_en;
    logic [DW-1:0]   req_wmask;
    logic [RW-1:0]   req_wdata;
    logic            rsp_valid;
    logic [RW-1:0]   rsp_rdata;

    ux607_dtag_ram_mway #(
        .NWAYS(NWAYS), .DP(DP), .AW(AW), .DW(DW), .INIT_VAL('0)
    ) dut (
        .clk(clk), .rst(rst), .ls(ls), .init_req(init_req), .init_busy(init_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_way_en(req_way_en), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;
    int max_run  = 0;

    logic [RW-1:0] exp_q [$];
    logic [DW-1:0] mdl [NWAYS][DP];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic mdl_sweep();
        for (int w = 0; w < NWAYS; w++)
            for (int a = 0; a < DP; a++)
                mdl[w][a] = '0;
    endtask

    // Assumes caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic do_req(input logic wen, input logic [AW-1:0] addr,
                          input logic [NWAYS-1:0] way, input logic [DW-1:0] mask,
                          input logic [RW-1:0] wdata);
        int n;
        logic [RW-1:0] e;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_way_en = way;
        req_wmask  = mask;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (wen) begin
            for (int w = 0; w < NWAYS; w++)
                if (way[w])
                    mdl[w][addr] = (mdl[w][addr] & ~mask) | (wdata[w*DW +: DW] & mask);
        end else begin
            for (int w = 0; w < NWAYS; w++)
                e[w*DW +: DW] = mdl[w][addr];
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts negedges with init_busy high; returns at posedge+1.
    task automatic busy_count(output int n);
        n = 0;
        @(negedge clk);
        while (init_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
            else chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [RW-1:0] hold;
        rst = 1'b1; ls = 1'b0; init_req = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_way_en = '0; req_wmask = '0; req_wdata = '0;

        // 1: reset, sweep length, reads return zero
        @(posedge clk); #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_init_busy", 64'(init_busy), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        mdl_sweep();
        busy_count(n);
        chk("init_busy_cycles", 64'(n), 64'd64);
        chk("ready_after_init", 64'(req_ready), 64'd1);
        do_req(1'b0, 6'd0, 2'b00, '0, '0);
        do_req(1'b0, 6'd5, 2'b00, '0, '0);
        do_req(1'b0, 6'd63, 2'b00, '0, '0);
        idle(2);

        // 2: single-way full write
        do_req(1'b1, 6'd5, 2'b10, 22'h3FFFFF, {22'h3ABCDE, 22'h111111});
        do_req(1'b0, 6'd5, 2'b00, '0, '0);
        idle(2);

        // 3: masked write to both ways
        do_req(1'b1, 6'd5, 2'b11, 22'h00000F, {22'h3FFFFF, 22'h3FFFFF});
        do_req(1'b0, 6'd5, 2'b00, '0, '0);
        // no-op writes
        do_req(1'b1, 6'd5, 2'b00, 22'h3FFFFF, {22'h000000, 22'h000000});
        do_req(1'b1, 6'd5, 2'b11, 22'h000000, {22'h000000, 22'h000000});
        do_req(1'b0, 6'd5, 2'b00, '0, '0);
        idle(2);

        // 4: back-to-back reads, then light sleep
        for (int a = 0; a < 4; a++)
            do_req(1'b1, AW'(a), 2'b11, 22'h3FFFFF, {DW'(22'h100 + a), DW'(22'h2A0000 + a * 3)});
        max_run = 0;
        for (int a = 0; a < 4; a++)
            do_req(1'b0, AW'(a), 2'b00, '0, '0);
        idle(2);
        chk("b2b_valid_run", 64'(max_run), 64'd4);
        do_req(1'b0, 6'd2, 2'b00, '0, '0);
        ls = 1'b1;
        #1;
        chk("ls_req_ready", 64'(req_ready), 64'd0);
        hold = exp_q.size() == 0 ? rsp_rdata : exp_q[0];
        repeat (4) @(negedge clk);
        chk("ls_rdata_hold", 64'(rsp_rdata), 64'(hold));
        chk("ls_no_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        ls = 1'b0;

        // 5: init_req with a write accepted the same cycle
        init_req = 1'b1;
        do_req(1'b1, 6'd9, 2'b11, 22'h3FFFFF, {22'h155555, 22'h2AAAAA});
        init_req = 1'b0;
        mdl_sweep();
        chk("init_req_busy", 64'(init_busy), 64'd1);
        busy_count(n);
        chk("init_req_cycles", 64'(n), 64'd64);
        do_req(1'b0, 6'd5, 2'b00, '0, '0);
        do_req(1'b0, 6'd9, 2'b00, '0, '0);
        // init_req with a read accepted the same cycle still responds
        do_req(1'b1, 6'd7, 2'b01, 22'h3FFFFF, {22'h0, 22'h0ABCDE});
        init_req = 1'b1;
        do_req(1'b0, 6'd7, 2'b00, '0, '0);
        init_req = 1'b0;
        mdl_sweep();
        busy_count(n);
        chk("init_req_rd_cycles", 64'(n), 64'd64);

        // 6: reset mid-sweep
        do_req(1'b1, 6'd40, 2'b11, 22'h3FFFFF, {22'h123456, 22'h3EDCBA});
        do_req(1'b0, 6'd40, 2'b00, '0, '0);
        idle(2);
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        // the edge just passed entered INIT with cnt=0; hold rst on the cnt=30 edge
        idle(29);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
        mdl_sweep();
        busy_count(n);
        chk("mid_rst_cycles", 64'(n), 64'd64);
        do_req(1'b0, 6'd40, 2'b00, '0, '0);
        do_req(1'b0, 6'd30, 2'b00, '0, '0);
        idle(3);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
